cu_chan_ctrl: RTL

- Sequential, parametrised successor to the combinational channel-decode control unit.
- Validates a mode/start command and latches a channel select.
- Arms the selected channel and waits for its ready with a bounded timeout, then holds a one-hot grant until the channel drops ready.
- Reports done, timeout and fault as single-cycle pulses. Sits between the command decoder and NCH channel datapaths.

---
 rtl/cu_chan_pkg.sv | 26 ++
 rtl/cu_tmo_cnt.sv | 26 ++
 rtl/cu_chan_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cu_chan_pkg.sv
// Shared types and helpers for the channel control unit: state encoding,
// mode constants and a select-to-one-hot helper.
package cu_chan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_REPEAT = 2'b01;

    localparam int unsigned OH_W = 32;

    // Callers truncate the result to their own channel count.
    function automatic logic [OH_W-1:0] onehot(input int unsigned sel, input int unsigned nch);
        logic [OH_W-1:0] v;
        v = '0;
        if (sel < nch && sel < OH_W)
            v = {{(OH_W-1){1'b0}}, 1'b1} << sel;
        return v;
    endfunction

endpackage

// File: rtl/cu_tmo_cnt.sv
// Saturating arm-timeout counter; expire_o flags the last permitted ARM cycle.
module cu_tmo_cnt #(
    parameter int unsigned TMO_W   = 4,
    parameter int unsigned TMO_CYC = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    logic [TMO_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (clr_i)
            cnt_q <= '0;
        else if (inc_i && cnt_q != '1)
            cnt_q <= cnt_q + TMO_W'(1);
    end

    assign expire_o = (cnt_q == TMO_W'(TMO_CYC - 1));

endmodule

// File: rtl/cu_chan_ctrl.sv
// Sequential channel control unit: validates a command, arms the selected
// channel with a bounded wait for ready, then grants it until ready drops.
module cu_chan_ctrl
    import cu_chan_pkg::*;
#(
    parameter int unsigned NCH     = 4,
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned TMO_W   = 4,
    parameter int unsigned TMO_CYC = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] sel,
    input  logic             abort,
    input  logic             inhibit,
    input  logic [NCH-1:0]   ch_rdy,
    output logic [NCH-1:0]   grant,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             fault,
    output logic [1:0]       state
);

    localparam logic [SEL_W:0] NCH_L = (SEL_W + 1)'(NCH);

    state_e           state_q;
    logic [SEL_W-1:0] sel_q;
    logic [1:0]       mode_q;
    logic [NCH-1:0]   grant_q;
    logic             busy_q, done_q, timeout_q, fault_q;

    logic [2**SEL_W-1:0] rdy_ext;
    logic legal, accept, reject, go, expire, cnt_clr, cnt_inc;

    // Widened so any select value indexes safely when NCH < 2**SEL_W.
    assign rdy_ext = (2**SEL_W)'(ch_rdy);

    always_comb begin
        legal   = ~mode[1] & ({1'b0, sel} < NCH_L);
        accept  = start & en & ~abort & legal;
        reject  = start & en & ~legal;
        go      = rdy_ext[sel_q] & ~inhibit;
        cnt_clr = ((state_q == IDLE) & accept)
                | ((state_q == DONE) & ~abort & (mode_q == MODE_REPEAT));
        cnt_inc = (state_q == ARM) & ~abort & ~go;
    end

    cu_tmo_cnt #(
        .TMO_W   (TMO_W),
        .TMO_CYC (TMO_CYC)
    ) u_tmo (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (cnt_clr),
        .inc_i    (cnt_inc),
        .expire_o (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            mode_q    <= MODE_SINGLE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            fault_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= ARM;
                        sel_q   <= sel;
                        mode_q  <= {1'b0, mode[0]};
                        busy_q  <= 1'b1;
                    end else if (reject) begin
                        fault_q <= 1'b1;
                    end
                end
                ARM: begin
                    // Ready beats the timeout when both land in the last ARM cycle.
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        grant_q <= '0;
                    end else if (go) begin
                        state_q <= RUN;
                        grant_q <= NCH'(onehot(32'(sel_q), NCH));
                    end else if (expire) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        grant_q <= '0;
                    end else if (!rdy_ext[sel_q]) begin
                        state_q <= DONE;
                        grant_q <= '0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (abort || mode_q != MODE_REPEAT) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        grant_q <= '0;
                    end else begin
                        state_q <= ARM;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign grant   = grant_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign timeout = timeout_q;
    assign fault   = fault_q;
    assign state   = state_q;

endmodule
